// File: rtl/seg_shift_pipe.sv
// Pipelined segmented shifter for the shared FP32 / dual-FP16 datapath.
// Right shift accumulates sticky bits and left shift accumulates overflow, per lane.
package FPALL_pkg;
  typedef enum logic {FP32 = 1'b0, FP16 = 1'b1} fp_fmt_e;
endpackage

module seg_shift_pipe
  import FPALL_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter bit REG_MID = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp_fmt_e          in_fmt,
  input  logic             in_dir,
  input  logic [23:0]      in_x,
  input  logic [7:0]       in_s,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [25:0]      out_r,
  output logic             out_stk_h,
  output logic             out_stk_l,
  output logic             out_ovf_h,
  output logic             out_ovf_l,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [25:0] r;
    logic        stk_h;
    logic        stk_l;
    logic        ovf_h;
    logic        ovf_l;
  } shv_t;

  // One fixed-distance stage. FP32 uses en_l for the whole vector; FP16 lanes are
  // shifted independently inside their 10-bit fields so nothing crosses the gap.
  function automatic shv_t shift_stage(input shv_t a, input fp_fmt_e fmt, input logic dir,
                                       input logic en_h, input logic en_l,
                                       input int unsigned k);
    shv_t        o;
    logic [25:0] m26_lo, m26_hi;
    logic [9:0]  m10_lo, m10_hi, hi, lo;
    o      = a;
    m26_lo = (26'h1 << k) - 26'h1;
    m26_hi = ~(26'h3ffffff >> k);
    m10_lo = (10'h1 << k) - 10'h1;
    m10_hi = ~(10'h3ff >> k);
    hi     = a.r[25:16];
    lo     = a.r[9:0];
    if (fmt == FP32) begin
      if (en_l) begin
        if (dir) begin
          o.ovf_l = a.ovf_l | (|(a.r & m26_hi));
          o.r     = a.r << k;
        end else begin
          o.stk_l = a.stk_l | (|(a.r & m26_lo));
          o.r     = a.r >> k;
        end
      end
    end else begin
      if (en_h) begin
        if (dir) begin
          o.ovf_h = a.ovf_h | (|(hi & m10_hi));
          hi      = hi << k;
        end else begin
          o.stk_h = a.stk_h | (|(hi & m10_lo));
          hi      = hi >> k;
        end
      end
      if (en_l) begin
        if (dir) begin
          o.ovf_l = a.ovf_l | (|(lo & m10_hi));
          lo      = lo << k;
        end else begin
          o.stk_l = a.stk_l | (|(lo & m10_lo));
          lo      = lo >> k;
        end
      end
      o.r = {hi, 6'b0, lo};
    end
    return o;
  endfunction

  // Front half: by-16 (FP32 only) and by-8 stages.
  shv_t f0, f1, f2;
  always_comb begin
    f0   = '0;
    f0.r = (in_fmt == FP32) ? {in_x, 2'b00}
                            : {in_x[23:16], 2'b00, 6'b0, in_x[7:0], 2'b00};
    f1   = shift_stage(f0, in_fmt, in_dir, 1'b0, (in_fmt == FP32) & in_s[4], 16);
    f2   = shift_stage(f1, in_fmt, in_dir, in_s[7], in_s[3], 8);
  end

  logic             out_adv;
  logic             b_valid;
  shv_t             b_w;
  fp_fmt_e          b_fmt;
  logic             b_dir;
  logic [7:0]       b_s;
  logic [TAG_W-1:0] b_tag;

  assign out_adv = !out_valid || out_ready;

  generate
    if (REG_MID) begin : g_mid
      logic             mid_valid;
      shv_t             mid_w;
      fp_fmt_e          mid_fmt;
      logic             mid_dir;
      logic [7:0]       mid_s;
      logic [TAG_W-1:0] mid_tag;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mid_valid <= 1'b0;
          mid_w     <= '0;
          mid_fmt   <= FP32;
          mid_dir   <= 1'b0;
          mid_s     <= '0;
          mid_tag   <= '0;
        end else if (flush) begin
          mid_valid <= 1'b0;
        end else if (in_ready) begin
          mid_valid <= in_valid;
          if (in_valid) begin
            mid_w   <= f2;
            mid_fmt <= in_fmt;
            mid_dir <= in_dir;
            mid_s   <= in_s;
            mid_tag <= in_tag;
          end
        end
      end

      assign in_ready = !mid_valid || out_adv;
      assign b_valid  = mid_valid;
      assign b_w      = mid_w;
      assign b_fmt    = mid_fmt;
      assign b_dir    = mid_dir;
      assign b_s      = mid_s;
      assign b_tag    = mid_tag;
    end else begin : g_nomid
      assign in_ready = out_adv;
      assign b_valid  = in_valid;
      assign b_w      = f2;
      assign b_fmt    = in_fmt;
      assign b_dir    = in_dir;
      assign b_s      = in_s;
      assign b_tag    = in_tag;
    end
  endgenerate

  // Back half: by-4, by-2, by-1 stages feeding the output register.
  shv_t b4, b2, b1;
  always_comb begin
    b4 = shift_stage(b_w, b_fmt, b_dir, b_s[6], b_s[2], 4);
    b2 = shift_stage(b4, b_fmt, b_dir, b_s[5], b_s[1], 2);
    b1 = shift_stage(b2, b_fmt, b_dir, b_s[4], b_s[0], 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_stk_h <= 1'b0;
      out_stk_l <= 1'b0;
      out_ovf_h <= 1'b0;
      out_ovf_l <= 1'b0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_adv) begin
      out_valid <= b_valid;
      if (b_valid) begin
        out_r     <= b1.r;
        out_stk_h <= b1.stk_h;
        out_stk_l <= b1.stk_l;
        out_ovf_h <= b1.ovf_h;
        out_ovf_l <= b1.ovf_l;
        out_tag   <= b_tag;
      end
    end
  end

endmodule

// File: tb/tb_seg_shift_pipe.sv
// Directed bench for seg_shift_pipe: shift vectors, backpressure ordering, flush and reset.
module tb_seg_shift_pipe;
  import FPALL_pkg::*;

  localparam int TAG_W   = 4;
  localparam bit REG_MID = 1'b1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  fp_fmt_e          in_fmt = FP32;
  logic             in_dir = 1'b0;
  logic [23:0]      in_x = '0;
  logic [7:0]       in_s = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [25:0]      out_r;
  logic             out_stk_h, out_stk_l, out_ovf_h, out_ovf_l;
  logic [TAG_W-1:0] out_tag;

  int tests = 0;
  int fails = 0;

  seg_shift_pipe #(.TAG_W(TAG_W), .REG_MID(REG_MID)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_dir(in_dir),
    .in_x(in_x), .in_s(in_s), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_stk_h(out_stk_h), .out_stk_l(out_stk_l), .out_ovf_h(out_ovf_h),
    .out_ovf_l(out_ovf_l), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one transaction into an empty pipe, wait for its result and check it.
  task automatic xact(input string name, input fp_fmt_e fmt, input logic dir,
                      input logic [23:0] x, input logic [7:0] s, input logic [3:0] tag,
                      input logic [25:0] er, input logic [3:0] eflags);
    int n;
    in_fmt = fmt; in_dir = dir; in_x = x; in_s = s; in_tag = tag; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_x = 24'h5A5A5A; in_s = 8'hFF; in_dir = ~dir;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk({name, ".lat"}, n, REG_MID);
    chk({name, ".r"}, out_r, er);
    chk({name, ".flags"}, {out_stk_h, out_stk_l, out_ovf_h, out_ovf_l}, eflags);
    chk({name, ".tag"}, out_tag, tag);
    tick();
  endtask

  task automatic set_in(input logic [3:0] t);
    in_fmt = FP32; in_dir = 1'b0; in_x = {20'h0, t}; in_s = 8'h00; in_tag = t;
  endtask

  initial begin
    int seen;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", out_valid, 0);
    chk("rst.ready", in_ready, 1);
    chk("rst.r", out_r, 0);
    chk("rst.tag", out_tag, 0);
    rst_n = 1'b1;
    tick();

    // Shift vectors; flags are {stk_h, stk_l, ovf_h, ovf_l}
    xact("fp32_r3",     FP32, 1'b0, 24'h800000, 8'd3,  4'h1, 26'h0400000, 4'b0000);
    xact("fp32_r3_stk", FP32, 1'b0, 24'h000001, 8'd3,  4'h2, 26'h0000000, 4'b0100);
    xact("fp16_r",      FP16, 1'b0, 24'hFF3C81, 8'h13, 4'h3, 26'h1FE0040, 4'b0100);
    xact("fp32_l22",    FP32, 1'b1, 24'h000001, 8'd22, 4'h4, 26'h1000000, 4'b0000);
    xact("fp32_l24",    FP32, 1'b1, 24'h000001, 8'd24, 4'h5, 26'h0000000, 4'b0001);
    xact("fp16_l",      FP16, 1'b1, 24'h400001, 8'h2F, 4'h6, 26'h0000000, 4'b0011);
    xact("fp32_amt0",   FP32, 1'b1, 24'hABCDEF, 8'd0,  4'h7, 26'h2AF37BC, 4'b0000);
    xact("fp32_r31",    FP32, 1'b0, 24'hFFFFFF, 8'd31, 4'h8, 26'h0000000, 4'b0100);
    xact("fp32_r26",    FP32, 1'b0, 24'h800000, 8'd26, 4'h9, 26'h0000000, 4'b0100);
    xact("fp32_r25",    FP32, 1'b0, 24'h800000, 8'd25, 4'hA, 26'h0000001, 4'b0000);
    xact("fp32_l5",     FP32, 1'b1, 24'h0ABCDE, 8'd5,  4'hB, 26'h15E6F00, 4'b0001);
    xact("fp16_r_stkh", FP16, 1'b0, 24'h030000, 8'h40, 4'hC, 26'h0000000, 4'b1000);
    xact("fp16_amt0",   FP16, 1'b1, 24'hA5FF3C, 8'h00, 4'hD, 26'h29400F0, 4'b0000);
    xact("fp16_l7",     FP16, 1'b1, 24'h010080, 8'h77, 4'hE, 26'h2000000, 4'b0001);
    xact("fp16_r9",     FP16, 1'b0, 24'hFF0000, 8'h90, 4'hF, 26'h0010000, 4'b1000);

    // Backpressure: two accepted, then stall, then in-order drain
    out_ready = 1'b0;
    set_in(4'd1); in_valid = 1'b1;
    chk("bp.rdy0", in_ready, 1);
    tick();
    set_in(4'd2);
    chk("bp.rdy1", in_ready, 1);
    tick();
    set_in(4'd3);
    chk("bp.full", in_ready, 0);
    chk("bp.valid", out_valid, 1);
    chk("bp.tag1", out_tag, 1);
    tick();
    chk("bp.still_full", in_ready, 0);
    chk("bp.tag1_stable", out_tag, 1);
    chk("bp.r1_stable", out_r, 26'h4);
    out_ready = 1'b1;
    #1;
    chk("bp.rdy_release", in_ready, 1);
    tick();
    chk("bp.tag2", out_tag, 2);
    chk("bp.r2", out_r, 26'h8);
    set_in(4'd4);
    tick();
    chk("bp.tag3", out_tag, 3);
    chk("bp.r3", out_r, 26'hC);
    in_valid = 1'b0;
    tick();
    chk("bp.tag4", out_tag, 4);
    chk("bp.valid4", out_valid, 1);
    tick();
    chk("bp.drained", out_valid, 0);

    // Flush with two in flight and a new offer on the same cycle
    out_ready = 1'b0;
    set_in(4'd5); in_valid = 1'b1;
    tick();
    set_in(4'd6);
    tick();
    chk("fl.pre_valid", out_valid, 1);
    flush = 1'b1;
    set_in(4'd7);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl.valid", out_valid, 0);
    chk("fl.ready", in_ready, 1);
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("fl.none_emerge", seen, 0);
    xact("post_flush", FP32, 1'b0, 24'h800000, 8'd3, 4'h5, 26'h0400000, 4'b0000);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    in_fmt = FP32; in_dir = 1'b1; in_x = 24'hFFFFFF; in_s = 8'd1; in_tag = 4'h8; in_valid = 1'b1;
    tick();
    in_tag = 4'h9;
    tick();
    in_valid = 1'b0;
    chk("ar.pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("ar.valid", out_valid, 0);
    chk("ar.r", out_r, 0);
    chk("ar.tag", out_tag, 0);
    chk("ar.flags", {out_stk_h, out_stk_l, out_ovf_h, out_ovf_l}, 0);
    chk("ar.ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    xact("post_rst", FP16, 1'b0, 24'hFF3C81, 8'h13, 4'h3, 26'h1FE0040, 4'b0100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
